// File: rtl/scs8hd_pgseq_pkg.sv
// Shared types and default timings for the scs8hd power-gating sequencer.
package scs8hd_pgseq_pkg;

    typedef enum logic [3:0] {
        ST_OFF     = 4'd0,
        ST_SW_ON   = 4'd1,
        ST_SETTLE  = 4'd2,
        ST_RST_REL = 4'd3,
        ST_ISO_REL = 4'd4,
        ST_ACTIVE  = 4'd5,
        ST_ISO_SET = 4'd6,
        ST_RST_SET = 4'd7,
        ST_SW_OFF  = 4'd8
    } pgseq_state_t;

    localparam int DEF_NGRP       = 4;
    localparam int DEF_STAGE_CYC  = 8;
    localparam int DEF_ISO_CYC    = 2;
    localparam int DEF_SETTLE_MAX = 64;
    localparam int DEF_CW         = 8;

    // OFF and ACTIVE are the only resting states; everything else is a sequence in flight.
    function automatic logic is_idle(input pgseq_state_t s);
        return (s == ST_OFF) || (s == ST_ACTIVE);
    endfunction

endpackage

// File: rtl/scs8hd_pgseq_sync.sv
// Two-flop synchronizer for the asynchronous domain supply-good level.
module scs8hd_pgseq_sync (
    input  logic CLK,
    input  logic RESETB,
    input  logic level,
    output logic level_sync
);

    logic meta;

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            meta       <= 1'b0;
            level_sync <= 1'b0;
        end else begin
            meta       <= level;
            level_sync <= meta;
        end
    end

endmodule

// File: rtl/scs8hd_pgseq_ctrl.sv
// Power-gating sequencer: staged header-switch enables, supply settle, then reset and
// isolation release; the reverse order on power-down. All outputs come straight from flops.
module scs8hd_pgseq_ctrl
    import scs8hd_pgseq_pkg::*;
#(
    parameter int NGRP       = DEF_NGRP,
    parameter int STAGE_CYC  = DEF_STAGE_CYC,
    parameter int ISO_CYC    = DEF_ISO_CYC,
    parameter int SETTLE_MAX = DEF_SETTLE_MAX,
    parameter int CW         = DEF_CW
) (
    input  logic            CLK,
    input  logic            RESETB,
    input  logic            pwr_req,
    output logic            pwr_ack,
    output logic            busy,
    output logic [NGRP-1:0] sw_en,
    output logic            iso_en,
    output logic            dom_resetb,
    input  logic            pwr_good,
    output logic            err,
    input  logic            err_clr
);

    localparam int            GW          = $clog2(NGRP) + 1;
    localparam logic [GW-1:0] GRP_ALL     = GW'(NGRP);
    localparam logic [CW-1:0] STAGE_LAST  = CW'(STAGE_CYC);
    localparam logic [CW-1:0] ISO_LAST    = CW'(ISO_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_MAX - 1);

    pgseq_state_t    state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [GW-1:0]   grp, grp_d;
    logic [NGRP-1:0] sw_en_d;
    logic            iso_en_d;
    logic            dom_resetb_d;
    logic            pwr_ack_d;
    logic            err_set;
    logic            step;
    logic            pwr_good_sync;

    scs8hd_pgseq_sync u_good_sync (
        .CLK        (CLK),
        .RESETB     (RESETB),
        .level      (pwr_good),
        .level_sync (pwr_good_sync)
    );

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state      <= ST_OFF;
            cnt        <= '0;
            grp        <= '0;
            sw_en      <= '0;
            iso_en     <= 1'b1;
            dom_resetb <= 1'b0;
            pwr_ack    <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            grp        <= grp_d;
            sw_en      <= sw_en_d;
            iso_en     <= iso_en_d;
            dom_resetb <= dom_resetb_d;
            pwr_ack    <= pwr_ack_d;
            busy       <= !is_idle(state);
            err        <= err_set | (err & ~err_clr);
        end
    end

    // Switch steps fire on the entry cycle and then every STAGE_CYC cycles; grp counts conducting groups.
    always_comb begin
        state_d      = state;
        cnt_d        = (cnt == '1) ? cnt : cnt + 1'b1;
        grp_d        = grp;
        sw_en_d      = sw_en;
        iso_en_d     = iso_en;
        dom_resetb_d = dom_resetb;
        pwr_ack_d    = pwr_ack;
        err_set      = 1'b0;
        step         = (cnt == '0) || (cnt == STAGE_LAST);

        case (state)
            ST_OFF: begin
                if (pwr_req && !err) state_d = ST_SW_ON;
            end
            ST_SW_ON: begin
                if (step) begin
                    if (grp == GRP_ALL) begin
                        state_d = ST_SETTLE;
                    end else begin
                        sw_en_d = (sw_en << 1) | NGRP'(1);
                        grp_d   = grp + 1'b1;
                        cnt_d   = CW'(1);
                    end
                end
            end
            // The entry cycle is a blanking cycle; pwr_good is trusted from the second cycle on.
            ST_SETTLE: begin
                if (pwr_good_sync && (cnt != '0)) begin
                    state_d = ST_RST_REL;
                end else if (cnt == SETTLE_LAST) begin
                    err_set = 1'b1;
                    state_d = ST_SW_OFF;
                end
            end
            ST_RST_REL: begin
                dom_resetb_d = 1'b1;
                if (cnt == ISO_LAST) state_d = ST_ISO_REL;
            end
            ST_ISO_REL: begin
                iso_en_d = 1'b0;
                state_d  = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                pwr_ack_d = 1'b1;
                if (!pwr_good_sync) begin
                    err_set = 1'b1;
                    state_d = ST_ISO_SET;
                end else if (!pwr_req) begin
                    state_d = ST_ISO_SET;
                end
            end
            ST_ISO_SET: begin
                iso_en_d  = 1'b1;
                pwr_ack_d = 1'b0;
                if (cnt == ISO_LAST) state_d = ST_RST_SET;
            end
            ST_RST_SET: begin
                dom_resetb_d = 1'b0;
                if (cnt == ISO_LAST) state_d = ST_SW_OFF;
            end
            ST_SW_OFF: begin
                if (grp == '0) begin
                    state_d = ST_OFF;
                end else if (step) begin
                    sw_en_d = sw_en >> 1;
                    grp_d   = grp - 1'b1;
                    cnt_d   = CW'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        if (state_d != state) cnt_d = '0;
    end

endmodule
